imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter N, default 64, address width in bits.
REQ-002 Parameter DEPTH, default 64, number of 32-bit instruction words (power of two).
REQ-003 Parameter LAT, default 2, read latency in cycles (LAT >= 1).
REQ-004 Parameter Q, default 4, response FIFO capacity and maximum outstanding requests.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  fetch presents an address.
REQ-008 req_addr  in  N  byte address, driven from the fetch stage imem_addr_F.
REQ-009 req_ready  out  1  responder accepts a request this cycle.
REQ-010 rsp_valid  out  1  response word available.
REQ-011 rsp_instr  out  32  instruction word.
REQ-012 rsp_err  out  1  address misaligned or out of range.
REQ-013 rsp_ready  in  1  consumer takes the response this cycle.
REQ-014 flush  in  1  discard all in-flight and buffered responses (branch taken).
REQ-015 load_en  in  1  memory write strobe.
REQ-016 load_addr  in  log2(DEPTH)  word index to write.
REQ-017 load_data  in  32  word to write.

Function
REQ-018 The block SHALL accept a request on a rising edge where req_valid=1 and req_ready=1.
REQ-019 req_ready SHALL be 1 iff outstanding < Q and flush=0 (combinational); outstanding = requests in the latency pipe plus FIFO entries.
REQ-020 On each edge, outstanding SHALL be +1 on accept only, -1 on retire (rsp_valid & rsp_ready) only, and unchanged on simultaneous accept and retire.
REQ-021 On accept, the memory SHALL be read at word index req_addr[log2(DEPTH)+1:2]; a load_en write to the same index on the same edge SHALL NOT be visible (old data returned).
REQ-022 If req_addr[1:0] != 0 or req_addr >= 4*DEPTH, the response SHALL carry rsp_err=1 and rsp_instr=32'hD503201F (NOP); otherwise rsp_err=0 and rsp_instr holds the memory word.
REQ-023 A request accepted at edge E SHALL enter the FIFO at edge E+LAT-1; with an empty FIFO, rsp_valid SHALL be 1 in the cycle following edge E+LAT-1 (LAT cycles after acceptance).
REQ-024 Responses SHALL be returned in acceptance order; back-to-back accepts SHALL yield back-to-back responses when rsp_ready=1.
REQ-025 rsp_valid SHALL equal FIFO non-empty; rsp_instr/rsp_err SHALL show the FIFO head.
REQ-026 While rsp_valid=1 and rsp_ready=0, rsp_instr and rsp_err SHALL hold stable.
REQ-027 The FIFO SHALL never overflow; this is guaranteed by REQ-019 alone.
REQ-028 Read pointers SHALL wrap modulo Q; FIFO full and empty SHALL be distinguished by the entry count.
REQ-029 On an edge with flush=1, all latency-pipe valids and FIFO entries SHALL be cleared and outstanding set to 0; rsp_valid SHALL be 0 in the next cycle; no request is accepted on that edge.
REQ-030 A retire coinciding with flush SHALL count as consumed; no response SHALL reappear after flush.
REQ-031 load_en SHALL write load_data to word load_addr on the edge, independent of requests and flush.

Reset
REQ-032 While reset=1 (asynchronously), outstanding=0, all pipe valids=0, FIFO empty, rsp_valid=0, rsp_instr=0, rsp_err=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 req_ready SHALL be 1 in the first cycle after reset deasserts (flush=0).
REQ-035 Reset asserted mid-operation SHALL discard all outstanding responses; none SHALL appear after release.

Verification
REQ-036 Load word0=32'h8B020020, word1=32'hF9400041; request 0x0 then 0x4 on consecutive edges, rsp_ready=1 -> rsp_valid 2 cycles after each accept, rsp_instr 8B020020 then F9400041, rsp_err=0.
REQ-037 Request 0x2 and 0x100 (DEPTH=64) -> two responses rsp_err=1, rsp_instr=D503201F.
REQ-038 rsp_ready=0, continuous req_valid -> exactly 4 accepts, req_ready=0 afterwards, rsp_instr stable on the head; raise rsp_ready -> 4 in-order responses, req_ready returns 1 after first retire.
REQ-039 3 outstanding requests, assert flush for 1 cycle -> rsp_valid=0 next cycle, outstanding=0, none of the 3 responses ever appear; next request returns normally.
REQ-040 load_en to word 5 = 32'h12345678 on the same edge as a request to 0x14 -> old word returned; a repeat request -> 12345678.
REQ-041 Assert reset asynchronously with 2 requests in the pipe -> outputs 0 immediately, no response after release, req_ready=1.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency reads into an in-order response FIFO,
// with credit-based request gating, misalignment/range errors and a flush.
module imem_responder #(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int LAT   = 2,
  parameter int Q     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [N-1:0]             req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_instr,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  input  logic                     flush,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(Q + 1);
  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [N-1:0] LIMIT = N'(4 * DEPTH);
  localparam logic [31:0]  NOP   = 32'hD503201F;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } rsp_t;

  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] out_cnt;
  logic          accept, retire, push;
  rsp_t          dat_in, push_dat;

  assign req_ready = (out_cnt < CW'(Q)) && !flush;
  assign accept    = req_valid && req_ready;
  assign retire    = rsp_valid && rsp_ready;

  // Memory is deliberately not reset; the read below sees pre-edge contents.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_comb begin
    dat_in.err   = (req_addr[1:0] != 2'b00) || (req_addr >= LIMIT);
    dat_in.instr = dat_in.err ? NOP : mem[req_addr[AW+1:2]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      out_cnt <= '0;
    else if (flush) out_cnt <= '0;
    else            out_cnt <= out_cnt + CW'(accept) - CW'(retire);
  end

  // LAT-1 register stages between accept and FIFO push.
  generate
    if (LAT == 1) begin : g_nopipe
      assign push     = accept;
      assign push_dat = dat_in;
    end else begin : g_pipe
      logic [LAT-1:1] vld_pipe;
      rsp_t [LAT-1:1] dat_pipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)      vld_pipe <= '0;
        else if (flush) vld_pipe <= '0;
        else begin
          vld_pipe[1] <= accept;
          for (int s = 2; s < LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
      end

      always_ff @(posedge clk) begin
        dat_pipe[1] <= dat_in;
        for (int s = 2; s < LAT; s++) dat_pipe[s] <= dat_pipe[s-1];
      end

      assign push     = vld_pipe[LAT-1];
      assign push_dat = dat_pipe[LAT-1];
    end
  endgenerate

  rsp_t          fifo [Q];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Q - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush) fifo[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (retire) rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(retire);
    end
  end

  // Outputs forced to zero when empty so reset shows clean zeros.
  assign rsp_valid = (cnt != '0);
  assign rsp_instr = rsp_valid ? fifo[rd_ptr].instr : '0;
  assign rsp_err   = rsp_valid ? fifo[rd_ptr].err   : 1'b0;

endmodule
